// File: rtl/point_stream_checker.sv
// Point-stream receiver: FIFO-buffered {A,B} samples, checked for A+1 / B-1 per byte.
// Build option POINT_CHECKER_RESYNC_EN: re-seed the expectation from the received sample on mismatch.
module point_stream_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             point_i_vld,
  output logic             point_i_rdy,
  input  logic [15:0]      point_i_A,
  input  logic [15:0]      point_i_B,
  input  logic             drain_en,
  output logic             locked,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic             err,
  output logic [15:0]      err_point_A,
  output logic [15:0]      err_point_B
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  // t_point packing: x in [15:8], y in [7:0]; bytes never carry into each other
  function automatic logic [15:0] pt_inc(input logic [15:0] p);
    logic [7:0] x;
    logic [7:0] y;
    x = p[15:8] + 8'd1;
    y = p[7:0] + 8'd1;
    return {x, y};
  endfunction

  function automatic logic [15:0] pt_dec(input logic [15:0] p);
    logic [7:0] x;
    logic [7:0] y;
    x = p[15:8] - 8'd1;
    y = p[7:0] - 8'd1;
    return {x, y};
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head_A;
  logic [15:0]   head_B;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign point_i_rdy = !full && !rst;
  assign push        = point_i_vld && point_i_rdy;
  assign pop         = drain_en && !empty && !rst;
  assign head_A      = mem[rd_ptr][31:16];
  assign head_B      = mem[rd_ptr][15:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {point_i_A, point_i_B};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  state_t          state_q, state_d;
  logic [15:0]     exp_A_q, exp_A_d;
  logic [15:0]     exp_B_q, exp_B_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic            err_q, err_d;
  logic [15:0]     epa_q, epa_d;
  logic [15:0]     epb_q, epb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      exp_A_q <= '0;
      exp_B_q <= '0;
      ok_q    <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      epa_q   <= '0;
      epb_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_A_q <= exp_A_d;
      exp_B_q <= exp_B_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      epa_q   <= epa_d;
      epb_q   <= epb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_A_d = exp_A_q;
    exp_B_d = exp_B_q;
    ok_d    = ok_q;
    bad_d   = bad_q;
    err_d   = err_q;
    epa_d   = epa_q;
    epb_d   = epb_q;
    if (pop) begin
      case (state_q)
        S_IDLE: begin
          exp_A_d = pt_inc(head_A);
          exp_B_d = pt_dec(head_B);
          state_d = S_LOCKED;
        end
        S_LOCKED: begin
          if (head_A == exp_A_q && head_B == exp_B_q) begin
            if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
            exp_A_d = pt_inc(head_A);
            exp_B_d = pt_dec(head_B);
          end else begin
            if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
            if (!err_q) begin
              err_d = 1'b1;
              epa_d = head_A;
              epb_d = head_B;
            end
`ifdef POINT_CHECKER_RESYNC_EN
            exp_A_d = pt_inc(head_A);
            exp_B_d = pt_dec(head_B);
`else
            exp_A_d = pt_inc(exp_A_q);
            exp_B_d = pt_dec(exp_B_q);
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign locked      = (state_q == S_LOCKED);
  assign cnt_ok      = ok_q;
  assign cnt_err     = bad_q;
  assign err         = err_q;
  assign err_point_A = epa_q;
  assign err_point_B = epb_q;

endmodule
